// File: rtl/forward_scoreboard.sv
// Operand forwarding and load-use hazard scoreboard for the RV32I pipeline.
// Tracks in-flight writers over DEPTH post-EX stages and resolves each source to its youngest producer.
module forward_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_en,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic                     issue_is_load,
  input  logic [4:0]               issue_rd,
  input  logic                     flush,
  input  logic [NUM_SRC*5-1:0]     src_rs,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic [NUM_SRC*32-1:0]    rf_data,
  input  logic [DEPTH*32-1:0]      stage_data,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [NUM_SRC*32-1:0]    fwd_data,
  output logic                     stall,
  output logic [15:0]              stall_cnt
);

  logic [DEPTH-1:0]      e_valid;
  logic [DEPTH-1:0]      e_we;
  logic [DEPTH-1:0]      e_load;
  logic [DEPTH-1:0][4:0] e_rd;
  logic [DEPTH-1:0]      e_writer;
  logic [NUM_SRC-1:0]    pend;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      e_writer[k] = e_valid[k] && e_we[k] && (e_rd[k] != 5'd0);
    end
  end

  always_comb begin
    logic [4:0] rs;
    logic       found;
    fwd_sel  = '0;
    fwd_data = '0;
    pend     = '0;
    rs       = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs    = src_rs[i*5 +: 5];
      found = 1'b0;
      if (rs != 5'd0) begin
        fwd_data[i*32 +: 32] = rf_data[i*32 +: 32];
      end
      if (src_used[i] && (rs != 5'd0)) begin
        // Youngest match wins; a not-yet-ready load blocks older stages.
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && e_writer[k] && (e_rd[k] == rs)) begin
            found = 1'b1;
            if (e_load[k] && (k < LOAD_READY)) begin
              pend[i] = 1'b1;
            end else begin
              fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
              fwd_data[i*32 +: 32]      = stage_data[k*32 +: 32];
            end
          end
        end
      end
    end
  end

  assign stall = issue_valid && (|pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid   <= '0;
      e_we      <= '0;
      e_load    <= '0;
      e_rd      <= '0;
      stall_cnt <= 16'd0;
    end else if (pipe_en) begin
      e_valid <= {e_valid[DEPTH-2:0], issue_valid && !flush && !stall};
      e_we    <= {e_we[DEPTH-2:0], issue_we};
      e_load  <= {e_load[DEPTH-2:0], issue_is_load};
      e_rd    <= {e_rd[DEPTH-2:0], issue_rd};
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed self-checking bench for forward_scoreboard with default parameters.
module tb_forward_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_en;
  logic        issue_valid;
  logic        issue_we;
  logic        issue_is_load;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [9:0]  src_rs;
  logic [1:0]  src_used;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [3:0]  fwd_sel;
  logic [63:0] fwd_data;
  logic        stall;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  forward_scoreboard dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .issue_valid(issue_valid),
    .issue_we(issue_we), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .flush(flush), .src_rs(src_rs), .src_used(src_used), .rf_data(rf_data),
    .stage_data(stage_data), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic we, input logic ld, input logic [4:0] rd);
    issue_valid   = v;
    issue_we      = we;
    issue_is_load = ld;
    issue_rd      = rd;
  endtask

  task automatic set_src(input logic [4:0] rs0, input logic u0, input logic [4:0] rs1, input logic u1);
    src_rs   = {rs1, rs0};
    src_used = {u1, u0};
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_issue(1'b0, 1'b0, 1'b0, 5'd0);
    flush   = 1'b0;
    pipe_en = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_issue(1'b1, 1'b1, 1'b0, 5'd5);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    rf_data    = {32'h0, 32'hAAAA_0000};
    stage_data = {32'h3333, 32'h2222, 32'h1111};
    set_src(5'd5, 1'b1, 5'd0, 1'b1);
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0000", stall_cnt); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_tests++; if (fwd_sel[1:0] !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", fwd_sel[1:0]); end
    n_tests++; if (fwd_data[31:0] !== 32'hAAAA_0000) begin n_fail++; $display("FAIL reset_data got=%h exp=aaaa0000", fwd_data[31:0]); end
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    set_issue(1'b1, 1'b1, 1'b0, 5'd5);
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd9);
    rf_data    = {32'h6666_0006, 32'h5555_0005};
    stage_data = {32'h0, 32'h0, 32'h1234};
    set_src(5'd5, 1'b1, 5'd6, 1'b1);
    n_tests++; if (fwd_sel[1:0] !== 2'd1) begin n_fail++; $display("FAIL alu_sel got=%0d exp=1", fwd_sel[1:0]); end
    n_tests++; if (fwd_data[31:0] !== 32'h1234) begin n_fail++; $display("FAIL alu_data got=%h exp=00001234", fwd_data[31:0]); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got=%b exp=0", stall); end
    n_tests++; if ({fwd_sel[3:2], fwd_data[63:32]} !== {2'd0, 32'h6666_0006}) begin n_fail++; $display("FAIL alu_src1 got=%0d/%h exp=0/66660006", fwd_sel[3:2], fwd_data[63:32]); end
  endtask

  task automatic test_priority();
    do_reset();
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b0, 5'd7);
    step();
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd0);
    rf_data    = {32'hFFFF_FFFF, 32'h7777_7777};
    stage_data = {32'h33, 32'h22, 32'h11};
    set_src(5'd7, 1'b1, 5'd0, 1'b1);
    n_tests++; if ({fwd_sel[1:0], fwd_data[31:0]} !== {2'd1, 32'h11}) begin n_fail++; $display("FAIL prio_young got=%0d/%h exp=1/00000011", fwd_sel[1:0], fwd_data[31:0]); end
    n_tests++; if ({fwd_sel[3:2], fwd_data[63:32]} !== {2'd0, 32'h0}) begin n_fail++; $display("FAIL prio_x0 got=%0d/%h exp=0/00000000", fwd_sel[3:2], fwd_data[63:32]); end
    set_src(5'd7, 1'b0, 5'd0, 1'b0);
    n_tests++; if ({fwd_sel[1:0], fwd_data[31:0]} !== {2'd0, 32'h7777_7777}) begin n_fail++; $display("FAIL prio_unused got=%0d/%h exp=0/77777777", fwd_sel[1:0], fwd_data[31:0]); end
    set_issue(1'b0, 1'b0, 1'b0, 5'd0);
    step();
    set_src(5'd7, 1'b1, 5'd0, 1'b0);
    n_tests++; if ({fwd_sel[1:0], fwd_data[31:0]} !== {2'd2, 32'h22}) begin n_fail++; $display("FAIL prio_stage1 got=%0d/%h exp=2/00000022", fwd_sel[1:0], fwd_data[31:0]); end
    step();
    #1;
    n_tests++; if ({fwd_sel[1:0], fwd_data[31:0]} !== {2'd3, 32'h33}) begin n_fail++; $display("FAIL prio_oldest got=%0d/%h exp=3/00000033", fwd_sel[1:0], fwd_data[31:0]); end
    step();
    #1;
    n_tests++; if ({fwd_sel[1:0], fwd_data[31:0]} !== {2'd0, 32'h7777_7777}) begin n_fail++; $display("FAIL prio_dropped got=%0d/%h exp=0/77777777", fwd_sel[1:0], fwd_data[31:0]); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd4);
    rf_data    = {32'h0, 32'h3030_3030};
    stage_data = {32'h0, 32'hDEAD_BEEF, 32'hBAD0_BAD0};
    set_src(5'd3, 1'b1, 5'd0, 1'b0);
    n_tests++; if ({stall, fwd_sel[1:0], fwd_data[31:0]} !== {1'b1, 2'd0, 32'h3030_3030}) begin n_fail++; $display("FAIL lu_pending got=%b/%0d/%h exp=1/0/30303030", stall, fwd_sel[1:0], fwd_data[31:0]); end
    issue_valid = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_gate got=%b exp=0", stall); end
    issue_valid = 1'b1;
    step();
    n_tests++; if ({stall, fwd_sel[1:0], fwd_data[31:0]} !== {1'b0, 2'd2, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL lu_resolve got=%b/%0d/%h exp=0/2/deadbeef", stall, fwd_sel[1:0], fwd_data[31:0]); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got=%h exp=0001", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd4);
    set_src(5'd3, 1'b1, 5'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if ({stall, stall_cnt} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL rst_mid got=%b/%h exp=0/0000", stall, stall_cnt); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd4);
    stage_data = {32'h0, 32'hDEAD_BEEF, 32'h0};
    set_src(5'd3, 1'b1, 5'd0, 1'b0);
    pipe_en = 1'b0;
    for (int c = 0; c < 4; c++) step();
    n_tests++; if ({stall, stall_cnt} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL mem_hold got=%b/%h exp=1/0000", stall, stall_cnt); end
    pipe_en = 1'b1;
    step();
    n_tests++; if ({stall, fwd_sel[1:0], stall_cnt} !== {1'b0, 2'd2, 16'd1}) begin n_fail++; $display("FAIL mem_resume got=%b/%0d/%h exp=0/2/0001", stall, fwd_sel[1:0], stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    rf_data    = {32'h0, 32'h0303_0303};
    stage_data = {32'h0, 32'h0, 32'hBAD0_0000};
    set_src(5'd3, 1'b1, 5'd0, 1'b0);
    n_tests++; if ({stall, fwd_sel[1:0], fwd_data[31:0]} !== {1'b0, 2'd0, 32'h0303_0303}) begin n_fail++; $display("FAIL flush_sq got=%b/%0d/%h exp=0/0/03030303", stall, fwd_sel[1:0], fwd_data[31:0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd4);
    set_src(5'd3, 1'b1, 5'd0, 1'b0);
    step();
    n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt); end
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    step();
    set_issue(1'b1, 1'b1, 1'b0, 5'd4);
    set_src(5'd3, 1'b1, 5'd0, 1'b0);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall got=%b exp=1", stall); end
    step();
    n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1; pipe_en = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    src_rs = '0; src_used = '0; rf_data = '0; stage_data = '0;
    test_reset();
    test_alu_back_to_back();
    test_priority();
    test_load_use();
    test_reset_mid_stall();
    test_mem_stall();
    test_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised operand forwarding and load-use hazard block for the pipelined RV32I core. It tracks in-flight register writers across DEPTH post-execute pipeline stages and resolves up to NUM_SRC source operands per cycle to the youngest matching producer. It generates the load-use stall and inserts bubbles, and it keeps a saturating stall-cycle counter. It sits between decode (ID) and the EX operand muxes and supersedes the fixed two-stage, two-operand forwarding logic.

## Interface
- NUM_SRC, 2: number of source operands resolved per cycle (ALU and comparator operands share the same ports).
- DEPTH, 3: number of tracked stages; stage 0 = EX/MEM, stage 1 = MEM/WB, higher = older.
- LOAD_READY, 1: lowest stage index at which load data is valid (0 < LOAD_READY < DEPTH).
- SEL_W, $clog2(DEPTH+1): width of one forwarding select.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pipe_en  in  1  pipeline advance enable; 0 during memory stalls.
- issue_valid  in  1  instruction in ID is valid and will enter EX.
- issue_we  in  1  issuing instruction writes the regfile.
- issue_is_load  in  1  issuing instruction is a load.
- issue_rd  in  5  issuing instruction destination (rv32i_reg).
- flush  in  1  issuing instruction is squashed (branch redirect).
- src_rs  in  NUM_SRC*5  source register indices of the instruction in ID.
- src_used  in  NUM_SRC  per-source: operand is read from a register (not imm/pc).
- rf_data  in  NUM_SRC*32  regfile read values per source.
- stage_data  in  DEPTH*32  result word held by each stage (ALU result, or MDR data where load data is valid).
- fwd_sel  out  NUM_SRC*SEL_W  per-source: 0 = regfile, k+1 = stage k.
- fwd_data  out  NUM_SRC*32  resolved operand per source.
- stall  out  1  load-use hazard; hold PC/IF/ID, bubble into EX.
- stall_cnt  out  16  saturating count of stalled advancing cycles.

## Operation
- Entry per stage: valid, we, is_load, rd[4:0]. Entry is a writer if valid && we && rd != 0.
- Shift on pipe_en=1: entry k moves to entry k+1, and entry DEPTH-1 is dropped. Entry 0 loads the issue fields if issue_valid && !flush && !stall. Otherwise entry 0 loads a bubble (valid=0).
- pipe_en=0: all entries, stall_cnt hold; outputs still evaluated from current entries.
- Per source i, if !src_used[i] or src_rs[i]==0: fwd_sel=0 and fwd_data=rf_data[i] when src_rs[i]!=0, or 32'd0 when src_rs[i]==0 (x0 is never forwarded).
- Otherwise, select the lowest k whose entry is a writer with rd==src_rs[i]:
  - Found, and entry k is a load with k < LOAD_READY: source i is pending. fwd_sel=0, fwd_data=rf_data[i]. There is no fall-through to older stages.
  - Found, not pending: fwd_sel=k+1, fwd_data=stage_data[k].
  - Not found: fwd_sel=0, fwd_data=rf_data[i].
- stall = OR of pending over all sources, gated by issue_valid.
- Counter: stall_cnt increments when stall && pipe_en, and saturates at 16'hFFFF.
- flush and stall together: the bubble is inserted once; flush does not affect entries 1..DEPTH-1.

## Timing
- Reset (rst=1 at clk edge): all entry valid bits cleared, stall_cnt=0. Next cycle: stall=0, fwd_sel=0, fwd_data=rf_data (0 for x0).
- rst has priority over pipe_en, issue and flush; a reset mid-stall clears the stall the following cycle.
- fwd_sel, fwd_data and stall are combinational from entries plus ID inputs. Zero-cycle latency; the consumer registers them into ID/EX.
- Producer in stage k is visible to the instruction that issues k+1 advancing cycles later.
- Load-use, default parameters: a dependent instruction directly behind a load sees stall=1 for exactly 1 advancing cycle. It then forwards from stage 1 (fwd_sel=2).
- Cycles with pipe_en=0 neither age entries nor count stalls.

## Test plan
- Reset: drive entries, assert rst one cycle -> stall_cnt=0, stall=0, fwd_sel=0 for src x5 with rf_data=32'hAAAA_0000, fwd_data=32'hAAAA_0000.
- ALU back-to-back: issue add x5 (we=1), then consumer src x5, stage_data[0]=32'h1234 -> fwd_sel=1, fwd_data=32'h1234, stall=0.
- Priority: x7 written in stage 0 (32'h11) and stage 1 (32'h22) -> fwd_sel=1, data 32'h11. Source x0 with stage writing x0 -> fwd_data=0, fwd_sel=0.
- Load-use: issue lw x3, then consumer of x3 -> stall=1 for 1 cycle, stall_cnt=1; next cycle fwd_sel=2, data=stage_data[1]=32'hDEAD_BEEF.
- Memory stall: pipe_en=0 for 4 cycles during load-use -> stall=1 held, stall_cnt unchanged, entries not shifted.
- Flush and saturation: flush with issue lw x3 -> a following x3 read forwards nothing, sel=0. Force stall_cnt to 16'hFFFF and stall again -> stall_cnt stays 16'hFFFF.
